// File: rtl/jtag_dma_pkg.sv
// Shared definitions for the JTAG DMA engine: FSM state encoding and burst limits.
package jtag_dma_pkg;

  localparam int MAX_BURST = 256;
  localparam int IDX_W     = $clog2(MAX_BURST);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_BEGIN,
    ST_WDATA,
    ST_WEND,
    ST_RDATA,
    ST_DONE
  } dma_state_e;

  // States in which a bus error aborts the burst.
  function automatic logic is_bus_phase(dma_state_e s);
    return (s == ST_REQ) || (s == ST_BEGIN) || (s == ST_WDATA) || (s == ST_RDATA);
  endfunction

endpackage

// File: rtl/jtag_dma_engine.sv
// Bus-master DMA stage: moves one burst between the ping-pong buffer and the system bus,
// and tells the JTAG controller when the buffer banks may be swapped.
module jtag_dma_engine
  import jtag_dma_pkg::*;
#(
  parameter int ADDR_W = 9
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       dma_address,
  input  logic [3:0]        dma_byte_enable,
  input  logic [7:0]        dma_burst_size,
  input  logic              dma_data_ready,
  input  logic              dma_readReady,
  output logic              switch_ready,
  output logic              dma_busy,
  output logic              dma_done,
  output logic              dma_error,
  output logic [ADDR_W-1:0] buf_address,
  output logic              buf_writeEnable,
  output logic [31:0]       buf_dataIn,
  input  logic [31:0]       buf_dataOut,
  output logic              requestTransaction,
  input  logic              transactionGranted,
  output logic              beginTransactionOut,
  output logic [31:0]       addressDataOut,
  output logic [3:0]        byteEnablesOut,
  output logic [7:0]        burstSizeOut,
  output logic              readNotWriteOut,
  output logic              dataValidOut,
  output logic              endTransactionOut,
  input  logic              busyIn,
  input  logic [31:0]       addressDataIn,
  input  logic              dataValidIn,
  input  logic              endTransactionIn,
  input  logic              errorIn
);

  dma_state_e       state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [3:0]       be_q, be_d;
  logic [7:0]       size_q, size_d;
  logic             rnw_q, rnw_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             rd_full_q, rd_full_d;
  logic             error_q, error_d;

  logic switch_ready_q, switch_ready_d;
  logic busy_q, busy_d;
  logic req_q, req_d;
  logic begin_q, begin_d;
  logic dvo_q, dvo_d;
  logic wend_q, wend_d;
  logic done_q, done_d;

  logic              rd_we;
  logic [ADDR_W-1:0] idx_ext;

  // rd_full_q marks that word burst_size has landed, so idx never has to count past 255.
  assign rd_we   = (state_q == ST_RDATA) && dataValidIn && !rd_full_q;
  assign idx_ext = ADDR_W'(idx_q);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    be_d      = be_q;
    size_d    = size_q;
    rnw_d     = rnw_q;
    idx_d     = idx_q;
    rd_full_d = rd_full_q;
    error_d   = error_q;

    case (state_q)
      ST_IDLE: begin
        if (dma_data_ready || dma_readReady) begin
          addr_d    = dma_address;
          be_d      = dma_byte_enable;
          size_d    = dma_burst_size;
          rnw_d     = !dma_data_ready;
          idx_d     = '0;
          rd_full_d = 1'b0;
          error_d   = 1'b0;
          state_d   = ST_REQ;
        end
      end
      ST_REQ: begin
        if (transactionGranted) state_d = ST_BEGIN;
      end
      ST_BEGIN: begin
        state_d = rnw_q ? ST_RDATA : ST_WDATA;
      end
      ST_WDATA: begin
        if (!busyIn) begin
          if (idx_q == size_q) state_d = ST_WEND;
          else                 idx_d   = idx_q + 1'b1;
        end
      end
      ST_WEND: begin
        state_d = ST_DONE;
      end
      ST_RDATA: begin
        if (rd_we) begin
          if (idx_q == size_q) rd_full_d = 1'b1;
          else                 idx_d     = idx_q + 1'b1;
        end
        if (endTransactionIn) state_d = ST_DONE;
      end
      ST_DONE: begin
        idx_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (is_bus_phase(state_q) && errorIn) begin
      error_d = 1'b1;
      state_d = ST_DONE;
    end

    switch_ready_d = (state_d == ST_IDLE);
    busy_d         = (state_d != ST_IDLE);
    req_d          = (state_d == ST_REQ) || (state_d == ST_BEGIN);
    begin_d        = (state_d == ST_BEGIN);
    dvo_d          = (state_d == ST_WDATA);
    wend_d         = (state_d == ST_WEND);
    done_d         = (state_d == ST_DONE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      addr_q         <= '0;
      be_q           <= '0;
      size_q         <= '0;
      rnw_q          <= 1'b0;
      idx_q          <= '0;
      rd_full_q      <= 1'b0;
      error_q        <= 1'b0;
      switch_ready_q <= 1'b1;
      busy_q         <= 1'b0;
      req_q          <= 1'b0;
      begin_q        <= 1'b0;
      dvo_q          <= 1'b0;
      wend_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      be_q           <= be_d;
      size_q         <= size_d;
      rnw_q          <= rnw_d;
      idx_q          <= idx_d;
      rd_full_q      <= rd_full_d;
      error_q        <= error_d;
      switch_ready_q <= switch_ready_d;
      busy_q         <= busy_d;
      req_q          <= req_d;
      begin_q        <= begin_d;
      dvo_q          <= dvo_d;
      wend_q         <= wend_d;
      done_q         <= done_d;
    end
  end

  // The buffer has one cycle of read latency, so in WDATA the address already points
  // at the word that will be shown next cycle: idx+1 on accept, idx while stalled.
  always_comb begin
    buf_address = '0;
    if (state_q == ST_WDATA)      buf_address = busyIn ? idx_ext : idx_ext + ADDR_W'(1);
    else if (state_q == ST_RDATA) buf_address = idx_ext;
  end

  assign buf_writeEnable     = rd_we;
  assign buf_dataIn          = rd_we ? addressDataIn : 32'h0;

  assign switch_ready        = switch_ready_q;
  assign dma_busy            = busy_q;
  assign dma_done            = done_q;
  assign dma_error           = error_q;
  assign requestTransaction  = req_q;
  assign beginTransactionOut = begin_q;
  assign dataValidOut        = dvo_q;
  assign endTransactionOut   = wend_q;

  assign addressDataOut  = begin_q ? addr_q : (dvo_q ? buf_dataOut : 32'h0);
  assign byteEnablesOut  = begin_q ? be_q   : 4'h0;
  assign burstSizeOut    = begin_q ? size_q : 8'h0;
  assign readNotWriteOut = begin_q & rnw_q;

endmodule

// File: tb/tb_jtag_dma_engine.sv
// Scenario bench for jtag_dma_engine with a ping-pong buffer model and a word scoreboard.
module tb_jtag_dma_engine;

  localparam int ADDR_W = 9;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [31:0]       dma_address = '0;
  logic [3:0]        dma_byte_enable = '0;
  logic [7:0]        dma_burst_size = '0;
  logic              dma_data_ready = 1'b0;
  logic              dma_readReady = 1'b0;
  logic              switch_ready, dma_busy, dma_done, dma_error;
  logic [ADDR_W-1:0] buf_address;
  logic              buf_writeEnable;
  logic [31:0]       buf_dataIn;
  logic [31:0]       buf_dataOut;
  logic              requestTransaction;
  logic              transactionGranted = 1'b0;
  logic              beginTransactionOut;
  logic [31:0]       addressDataOut;
  logic [3:0]        byteEnablesOut;
  logic [7:0]        burstSizeOut;
  logic              readNotWriteOut, dataValidOut, endTransactionOut;
  logic              busyIn = 1'b0;
  logic [31:0]       addressDataIn = '0;
  logic              dataValidIn = 1'b0;
  logic              endTransactionIn = 1'b0;
  logic              errorIn = 1'b0;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [0:(1<<ADDR_W)-1];
  logic        fill_req = 1'b0;
  logic [31:0] fill_seed = '0;
  logic [31:0] seed_cur = '0;
  logic [31:0]       exp_q[$];
  logic [ADDR_W-1:0] exp_addr_q[$];

  jtag_dma_engine #(.ADDR_W(ADDR_W)) dut (
    .clock(clock), .reset(reset),
    .dma_address(dma_address), .dma_byte_enable(dma_byte_enable),
    .dma_burst_size(dma_burst_size), .dma_data_ready(dma_data_ready),
    .dma_readReady(dma_readReady), .switch_ready(switch_ready),
    .dma_busy(dma_busy), .dma_done(dma_done), .dma_error(dma_error),
    .buf_address(buf_address), .buf_writeEnable(buf_writeEnable),
    .buf_dataIn(buf_dataIn), .buf_dataOut(buf_dataOut),
    .requestTransaction(requestTransaction), .transactionGranted(transactionGranted),
    .beginTransactionOut(beginTransactionOut), .addressDataOut(addressDataOut),
    .byteEnablesOut(byteEnablesOut), .burstSizeOut(burstSizeOut),
    .readNotWriteOut(readNotWriteOut), .dataValidOut(dataValidOut),
    .endTransactionOut(endTransactionOut), .busyIn(busyIn),
    .addressDataIn(addressDataIn), .dataValidIn(dataValidIn),
    .endTransactionIn(endTransactionIn), .errorIn(errorIn)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] pattern(input int i, input logic [31:0] seed);
    return (32'(i) * 32'h0001_0003) ^ seed;
  endfunction

  // Synchronous-read buffer: data appears one cycle after its address.
  always @(posedge clock) begin
    if (fill_req) begin
      for (int i = 0; i < (1 << ADDR_W); i++) mem[i] <= pattern(i, fill_seed);
    end else if (buf_writeEnable) begin
      mem[buf_address] <= buf_dataIn;
    end
    buf_dataOut <= mem[buf_address];
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic fill_mem(input logic [31:0] seed);
    @(posedge clock); #1;
    fill_seed = seed;
    seed_cur  = seed;
    fill_req  = 1'b1;
    @(posedge clock); #1;
    fill_req  = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [3:0] be, input logic [7:0] size,
                          input int stall_word, input int stall_cycles, input int err_word,
                          input logic with_read, input logic mid_read, input string name);
    int   accepted = 0, stalled = 0, dv_cycles = 0, budget = 0, exp_acc, exp_dv;
    logic saw_end = 1'b0, saw_done = 1'b0;
    exp_q.delete();
    for (int i = 0; i <= int'(size); i++) exp_q.push_back(pattern(i, seed_cur));
    exp_acc = (err_word >= 0) ? err_word + 1 : int'(size) + 1;
    exp_dv  = exp_acc + stall_cycles;

    @(posedge clock); #1;
    dma_address = addr; dma_byte_enable = be; dma_burst_size = size;
    dma_data_ready = 1'b1; dma_readReady = with_read;
    @(posedge clock); #1;
    dma_data_ready = 1'b0; dma_readReady = 1'b0;
    dma_address = '0; dma_byte_enable = '0; dma_burst_size = '0;
    @(negedge clock);
    checks++;
    if ({requestTransaction, switch_ready, dma_busy, dma_error} !== 4'b1010) begin
      errors++;
      $display("[TB] FAIL %s req_state: got req/sw/busy/err=%b expected 1010", name,
               {requestTransaction, switch_ready, dma_busy, dma_error});
    end

    @(posedge clock); #1 transactionGranted = 1'b1;
    @(posedge clock); #1 transactionGranted = 1'b0;
    @(negedge clock);
    checks++;
    if ({beginTransactionOut, requestTransaction, readNotWriteOut} !== 3'b110 ||
        addressDataOut !== addr || burstSizeOut !== size || byteEnablesOut !== be ||
        buf_address !== '0) begin
      errors++;
      $display("[TB] FAIL %s begin_phase: got beg/req/rnw=%b addr=%h size=%h be=%h buf=%h expected 110 %h %h %h 0",
               name, {beginTransactionOut, requestTransaction, readNotWriteOut},
               addressDataOut, burstSizeOut, byteEnablesOut, buf_address, addr, size, be);
    end

    while (!saw_done && budget < 600) begin
      @(posedge clock); #1;
      busyIn        = (accepted == stall_word) && (stalled < stall_cycles);
      errorIn       = (accepted == err_word);
      dma_readReady = mid_read && (dv_cycles == 1);
      @(negedge clock);
      if (budget == 0) begin
        checks++;
        if (dataValidOut !== 1'b1) begin
          errors++;
          $display("[TB] FAIL %s first_word_timing: got dataValidOut=%b expected 1", name, dataValidOut);
        end
      end
      if (dma_done) saw_done = 1'b1;
      if (endTransactionOut) saw_end = 1'b1;
      if (dataValidOut) begin
        dv_cycles++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL %s extra_word: got %h expected no word", name, addressDataOut);
        end else if (addressDataOut !== exp_q[0]) begin
          errors++;
          $display("[TB] FAIL %s write_word[%0d]: got %h expected %h", name, accepted, addressDataOut, exp_q[0]);
        end
        if (!busyIn) begin
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          accepted++;
        end else begin
          stalled++;
        end
      end
      budget++;
    end
    busyIn = 1'b0; errorIn = 1'b0; dma_readReady = 1'b0;

    checks++;
    if (!saw_done) begin
      errors++;
      $display("[TB] FAIL %s done_timeout: got no dma_done in %0d cycles expected pulse", name, budget);
    end
    checks++;
    if (saw_end !== (err_word < 0)) begin
      errors++;
      $display("[TB] FAIL %s end_strobe: got %b expected %b", name, saw_end, err_word < 0);
    end
    checks++;
    if (accepted != exp_acc || dv_cycles != exp_dv) begin
      errors++;
      $display("[TB] FAIL %s word_count: got accepted=%0d cycles=%0d expected %0d %0d",
               name, accepted, dv_cycles, exp_acc, exp_dv);
    end
    checks++;
    if (dma_error !== (err_word >= 0)) begin
      errors++;
      $display("[TB] FAIL %s error_flag: got %b expected %b", name, dma_error, err_word >= 0);
    end
    exp_q.delete();

    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      checks++;
      if ({switch_ready, dma_busy, dma_done, requestTransaction} !== 4'b1000 ||
          dma_error !== (err_word >= 0)) begin
        errors++;
        $display("[TB] FAIL %s idle_after[%0d]: got sw/busy/done/req=%b err=%b expected 1000 %b",
                 name, c, {switch_ready, dma_busy, dma_done, requestTransaction}, dma_error, err_word >= 0);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checks++;
    if ({switch_ready, dma_busy, dma_done, dma_error, requestTransaction, beginTransactionOut,
         dataValidOut, endTransactionOut, buf_writeEnable} !== 9'b1_0000_0000 ||
        addressDataOut !== '0 || buf_address !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got sw=%b busy=%b req=%b ado=%h buf=%h expected sw=1 others 0",
               switch_ready, dma_busy, requestTransaction, addressDataOut, buf_address);
    end
    #1 reset = 1'b0;
    @(negedge clock);
    checks++;
    if (switch_ready !== 1'b1 || dma_busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_release: got sw=%b busy=%b expected 1 0", switch_ready, dma_busy);
    end
  endtask

  task automatic test_write_burst();
    fill_mem(32'hC0DE_0000);
    do_write(32'h4000_0010, 4'hF, 8'd3, -1, 0, -1, 1'b0, 1'b0, "write_burst");
  endtask

  task automatic test_write_stall();
    fill_mem(32'h1234_5000);
    do_write(32'h4000_0200, 4'h3, 8'd5, 1, 3, -1, 1'b0, 1'b0, "write_stall");
  endtask

  task automatic test_read_burst();
    logic [31:0] words [3];
    words[0] = 32'hDEAD_0001; words[1] = 32'hDEAD_0002; words[2] = 32'hDEAD_0003;
    fill_mem(32'h7700_0000);
    exp_q.delete(); exp_addr_q.delete();
    exp_q.push_back(words[0]); exp_addr_q.push_back(ADDR_W'(0));
    exp_q.push_back(words[1]); exp_addr_q.push_back(ADDR_W'(1));

    @(posedge clock); #1;
    dma_address = 32'h8000_0100; dma_byte_enable = 4'h3; dma_burst_size = 8'd1; dma_readReady = 1'b1;
    @(posedge clock); #1;
    dma_readReady = 1'b0; transactionGranted = 1'b1;
    @(posedge clock); #1 transactionGranted = 1'b0;
    @(negedge clock);
    checks++;
    if ({beginTransactionOut, readNotWriteOut} !== 2'b11 || addressDataOut !== 32'h8000_0100 ||
        burstSizeOut !== 8'd1 || byteEnablesOut !== 4'h3) begin
      errors++;
      $display("[TB] FAIL read_begin: got beg/rnw=%b addr=%h size=%h be=%h expected 11 80000100 01 3",
               {beginTransactionOut, readNotWriteOut}, addressDataOut, burstSizeOut, byteEnablesOut);
    end

    for (int k = 0; k < 3; k++) begin
      @(posedge clock); #1;
      dataValidIn = 1'b1; addressDataIn = words[k];
      @(negedge clock);
      checks++;
      if (exp_q.size() != 0) begin
        if (buf_writeEnable !== 1'b1 || buf_address !== exp_addr_q[0] || buf_dataIn !== exp_q[0]) begin
          errors++;
          $display("[TB] FAIL read_word[%0d]: got we=%b addr=%h data=%h expected 1 %h %h",
                   k, buf_writeEnable, buf_address, buf_dataIn, exp_addr_q[0], exp_q[0]);
        end
        void'(exp_q.pop_front()); void'(exp_addr_q.pop_front());
      end else if (buf_writeEnable !== 1'b0) begin
        errors++;
        $display("[TB] FAIL read_extra_word: got we=%b expected 0", buf_writeEnable);
      end
    end
    @(posedge clock); #1;
    dataValidIn = 1'b0; addressDataIn = '0; endTransactionIn = 1'b1;
    @(posedge clock); #1 endTransactionIn = 1'b0;
    @(negedge clock);
    checks++;
    if (dma_done !== 1'b1 || dma_error !== 1'b0) begin
      errors++;
      $display("[TB] FAIL read_done: got done=%b err=%b expected 1 0", dma_done, dma_error);
    end
    @(negedge clock);
    checks++;
    if (mem[0] !== words[0] || mem[1] !== words[1] || mem[2] !== pattern(2, seed_cur) ||
        switch_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL read_buffer: got %h %h %h sw=%b expected %h %h %h 1",
               mem[0], mem[1], mem[2], switch_ready, words[0], words[1], pattern(2, seed_cur));
    end
  endtask

  task automatic test_error_abort();
    fill_mem(32'h0E0E_0000);
    do_write(32'h4000_1000, 4'hF, 8'd7, -1, 0, 2, 1'b0, 1'b0, "error_abort");
    do_write(32'h4000_2000, 4'h1, 8'd0, -1, 0, -1, 1'b0, 1'b0, "error_clear");
  endtask

  task automatic test_back_to_back();
    fill_mem(32'hB2B0_0000);
    do_write(32'h4000_3000, 4'hC, 8'd2, -1, 0, -1, 1'b1, 1'b1, "back_to_back");
  endtask

  task automatic test_reset_mid_burst();
    fill_mem(32'h5A5A_0000);
    @(posedge clock); #1;
    dma_address = 32'h4000_4000; dma_byte_enable = 4'hF; dma_burst_size = 8'd7; dma_data_ready = 1'b1;
    @(posedge clock); #1;
    dma_data_ready = 1'b0; transactionGranted = 1'b1;
    @(posedge clock); #1 transactionGranted = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checks++;
    if (dataValidOut !== 1'b1 || addressDataOut !== pattern(1, seed_cur)) begin
      errors++;
      $display("[TB] FAIL reset_mid_pre: got dv=%b data=%h expected 1 %h", dataValidOut, addressDataOut, pattern(1, seed_cur));
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({requestTransaction, dataValidOut, endTransactionOut, dma_busy, dma_done, switch_ready} !== 6'b000001 ||
        addressDataOut !== '0 || buf_address !== '0) begin
      errors++;
      $display("[TB] FAIL reset_mid_async: got req/dv/end/busy/done/sw=%b ado=%h buf=%h expected 000001 0 0",
               {requestTransaction, dataValidOut, endTransactionOut, dma_busy, dma_done, switch_ready},
               addressDataOut, buf_address);
    end
    @(posedge clock); #1 reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      checks++;
      if (switch_ready !== 1'b1 || requestTransaction !== 1'b0 || endTransactionOut !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_mid_idle[%0d]: got sw=%b req=%b end=%b expected 1 0 0",
                 c, switch_ready, requestTransaction, endTransactionOut);
      end
    end
    do_write(32'h4000_5000, 4'hF, 8'd1, -1, 0, -1, 1'b0, 1'b0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_write_burst();
    test_write_stall();
    test_read_burst();
    test_error_abort();
    test_back_to_back();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jtag_dma_engine.md
# jtag_dma_engine

Bus-master DMA stage directly downstream of the JTAG chain-1 controller. Accepts single-cycle launch pulses (write or read) with address, byte enables and burst size. Moves one burst between the DMA-side port of the ping-pong buffer and the system bus: buffer to bus for writes, bus to buffer for reads. Drives `switch_ready` back to the controller so buffer banks swap only while no burst is in flight.

## Interface
Parameters:
- `ADDR_W`, 9: ping-pong buffer address width (bank size 2^ADDR_W words).

Ports:
- `clock`  in  1  system clock; everything below is synchronous to it.
- `reset`  in  1  asynchronous, active-high reset.
- `dma_address`  in  32  bus start address; sampled on a launch pulse.
- `dma_byte_enable`  in  4  byte enables; sampled on a launch pulse.
- `dma_burst_size`  in  8  number of words minus 1 (0..255); sampled on a launch pulse.
- `dma_data_ready`  in  1  one-cycle write-launch pulse.
- `dma_readReady`  in  1  one-cycle read-launch pulse.
- `switch_ready`  out  1  high only in IDLE.
- `dma_busy`  out  1  high in every state except IDLE.
- `dma_done`  out  1  one-cycle pulse when a burst completes or aborts.
- `dma_error`  out  1  sticky bus-error flag; cleared by the next launch.
- `buf_address`  out  ADDR_W  DMA-side buffer address.
- `buf_writeEnable`  out  1  buffer write strobe.
- `buf_dataIn`  out  32  buffer write data.
- `buf_dataOut`  in  32  buffer read data; valid 1 cycle after its address.
- `requestTransaction`  out  1  bus request.
- `transactionGranted`  in  1  bus grant.
- `beginTransactionOut`  out  1  address-phase strobe.
- `addressDataOut`  out  32  address in the begin cycle, write data in data cycles.
- `byteEnablesOut`  out  4  byte enables in the begin cycle.
- `burstSizeOut`  out  8  burst size in the begin cycle.
- `readNotWriteOut`  out  1  1 = read; valid in the begin cycle.
- `dataValidOut`  out  1  write word valid.
- `endTransactionOut`  out  1  master end-of-write strobe.
- `busyIn`  in  1  slave stall; a write word is accepted only when `busyIn` is 0.
- `addressDataIn`  in  32  read data from the bus.
- `dataValidIn`  in  1  read word valid.
- `endTransactionIn`  in  1  slave end-of-read.
- `errorIn`  in  1  bus error.

## Operation
- Launch: in IDLE, capture address, byte enables, burst size and direction; clear `dma_error`; go to REQ.
  - If write and read pulses arrive together, the write wins and the read is dropped.
  - Pulses outside IDLE are ignored.
- REQ: hold `requestTransaction`=1 until `transactionGranted`=1, then go to BEGIN.
- BEGIN (1 cycle):
  - Drive `beginTransactionOut`=1, address, byte enables, burst size and `readNotWriteOut`.
  - Hold `requestTransaction`=1 through this cycle.
  - For writes, present buffer address 0. Next state is WDATA or RDATA.
- WDATA, per data cycle:
  - Drive `dataValidOut`=1 with buffer word `idx`.
  - The word is accepted when `busyIn`=0; then `idx` increments.
  - While `busyIn`=1, hold both the word and the buffer address.
  - After word `burst_size` is accepted, go to WEND.
- WEND (1 cycle): `endTransactionOut`=1, then go to DONE.
- RDATA:
  - Each cycle with `dataValidIn`=1 and `idx` ≤ `burst_size`: write `addressDataIn` to buffer[`idx`] with `buf_writeEnable`=1, then increment `idx`.
  - Words beyond `burst_size` are discarded.
  - `endTransactionIn`=1 goes to DONE, even if the burst is short.
- `errorIn`=1 in REQ, BEGIN, WDATA or RDATA: set `dma_error` and go to DONE without asserting `endTransactionOut`.
- DONE (1 cycle): `dma_done`=1, release the request, then go to IDLE.
- `idx` is an 8-bit counter zero-extended to ADDR_W. It cannot wrap, because a burst is at most 256 words and a bank holds 512.

## Timing
- Reset value of every output is 0, except `switch_ready`, which is 1 because the block resets to IDLE.
  - `dma_error` is cleared; `idx` is 0.
  - Reset mid-burst drops the bus request immediately, with no end strobe.
- Launch pulse at cycle 0 → REQ and `requestTransaction`=1 at cycle 1; `switch_ready` falls at cycle 1.
- Grant at cycle n → BEGIN at n+1; first write word at n+2 with zero stall.
- An unstalled write of N words occupies N cycles of `dataValidOut`, then WEND, then DONE. `switch_ready` returns 1 the cycle after DONE.
- All bus outputs are 0 in cycles where the state does not drive them.
- Buffer data used in WDATA comes from the address presented the previous cycle; the address must lead the data by exactly 1 cycle, including across stalls.

## Structure
- Shared package `jtag_dma_pkg`: state encoding (IDLE, REQ, BEGIN, WDATA, WEND, RDATA, DONE) and the maximum burst constant (256).
- Single module; no sub-module is required.

## Test plan
- Write burst, size 3, address 0x4000_0010, BE 0xF, no stall → begin carries 0x4000_0010 and size 3; 4 data cycles carrying buffer words 0..3; end strobe; `dma_done` pulse; `switch_ready`=1.
- Write with `busyIn`=1 for 3 cycles on word 1 → word 1 is held stable for 4 cycles; no word is skipped or duplicated.
- Read burst, size 1 → 2 `dataValidIn` words land at buffer 0 and 1; `endTransactionIn` → DONE; a third extra word is discarded.
- `errorIn` mid-write at word 2 of 8 → `dma_error`=1, no `endTransactionOut`, `dma_done` pulse; the next launch clears `dma_error`.
- Simultaneous write and read pulses → write burst only; a read pulse during a busy burst is ignored.
- `reset` asserted in WDATA → all outputs 0 asynchronously; IDLE with `switch_ready`=1 after release.
